// File: rtl/spireg_regfile.sv
// spireg_regfile: register bank behind the spireg SPI slave.
//
// Holds ID, CTRL, IRQ_FLAG (W1C), IRQ_MASK, four read-only input words (IN0..IN3)
// and four general-purpose words (GP0..GP3). Also decodes fast commands into
// soft reset, IRQ clear, snapshot and forwarded user commands.
//
// Optional feature macro: SPIREG_REGFILE_SNAPSHOT_EN
//   defined   : IN0..IN3 read a shadow copy of in_data, captured on fast command
//               0x03 or on a fresh read access of IN0; status[6] reports snap_vld.
//   undefined : IN0..IN3 read in_data live; 0x03 is a NOP; status[6] is 0.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   reg_addr        register word address from spireg
//   reg_data_o      write data from spireg
//   reg_data_o_vld  one-cycle write strobe
//   reg_data_i      registered read data to spireg (1 clk latency)
//   status          {irq, snap_vld, irq_flag[5:0]}, registered
//   fastcmd(_vld)   fast command code and strobe
//   irq_src         rising-edge interrupt sources
//   in_data         four read-only input words, word k at [k*REG_W +: REG_W]
//   ctrl_o, gp_o    CTRL and GP0..GP3 register contents
//   irq             registered |(irq_flag & irq_mask)
//   user_cmd(_vld)  forwarded fast command code and one-cycle pulse

module spireg_regfile #(
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       REG_W    = 16,
  parameter logic [15:0]       ID_VAL   = 16'h5A01,
  parameter logic [REG_W-1:0]  CTRL_RST = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    reg_addr,
  input  logic [REG_W-1:0]     reg_data_o,
  input  logic                 reg_data_o_vld,
  output logic [REG_W-1:0]     reg_data_i,
  output logic [7:0]           status,
  input  logic [5:0]           fastcmd,
  input  logic                 fastcmd_vld,
  input  logic [7:0]           irq_src,
  input  logic [4*REG_W-1:0]   in_data,
  output logic [REG_W-1:0]     ctrl_o,
  output logic [4*REG_W-1:0]   gp_o,
  output logic                 irq,
  output logic [5:0]           user_cmd,
  output logic                 user_cmd_vld
);

  localparam logic [REG_W-1:0]  IdWord   = REG_W'(ID_VAL);
  localparam logic [ADDR_W-1:0] AddrId   = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] AddrCtrl = ADDR_W'(8'h01);
  localparam logic [ADDR_W-1:0] AddrFlag = ADDR_W'(8'h02);
  localparam logic [ADDR_W-1:0] AddrMask = ADDR_W'(8'h03);
  localparam logic [ADDR_W-1:0] AddrIn0  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] AddrIn1  = ADDR_W'(8'h05);
  localparam logic [ADDR_W-1:0] AddrIn2  = ADDR_W'(8'h06);
  localparam logic [ADDR_W-1:0] AddrIn3  = ADDR_W'(8'h07);
  localparam logic [ADDR_W-1:0] AddrGp0  = ADDR_W'(8'h08);
  localparam logic [ADDR_W-1:0] AddrGp1  = ADDR_W'(8'h09);
  localparam logic [ADDR_W-1:0] AddrGp2  = ADDR_W'(8'h0A);
  localparam logic [ADDR_W-1:0] AddrGp3  = ADDR_W'(8'h0B);

  localparam logic [5:0] FcSoftRst = 6'h01;
  localparam logic [5:0] FcIrqClr  = 6'h02;
  localparam logic [5:0] FcUserMin = 6'h04;

  // State
  logic [REG_W-1:0]   ctrl_q, ctrl_d;
  logic [7:0]         mask_q, mask_d;
  logic [7:0]         flag_q, flag_d;
  logic [4*REG_W-1:0] gp_q, gp_d;
  logic [7:0]         hist_q, hist_d;
  logic [7:0]         edge_q, edge_d;
  logic               arm_q, arm_d;
  logic               irq_q, irq_d;
  logic [7:0]         status_q, status_d;
  logic [REG_W-1:0]   rdata_q, rdata_d;
  logic [5:0]         user_cmd_q, user_cmd_d;
  logic               user_cmd_vld_q, user_cmd_vld_d;

  // Decode
  logic               wr_en;
  logic               fc_soft;
  logic               fc_clr;
  logic               fc_user;
  logic [4*REG_W-1:0] in_view;
  logic               snap_vld;

  assign wr_en   = reg_data_o_vld;
  assign fc_soft = fastcmd_vld && (fastcmd == FcSoftRst);
  assign fc_clr  = fastcmd_vld && (fastcmd == FcIrqClr);
  assign fc_user = fastcmd_vld && (fastcmd >= FcUserMin);

`ifdef SPIREG_REGFILE_SNAPSHOT_EN
  localparam logic [5:0] FcSnap = 6'h03;

  logic [4*REG_W-1:0] shadow_q, shadow_d;
  logic               snap_vld_q, snap_vld_d;
  logic [ADDR_W-1:0]  prev_addr_q, prev_addr_d;
  logic               snap_trig;

  // A read access of IN0 is recognised by the address arriving at IN0, so a
  // multi-word burst starting at IN0 sees one coherent capture.
  assign snap_trig = (fastcmd_vld && (fastcmd == FcSnap)) ||
                     ((reg_addr == AddrIn0) && (prev_addr_q != AddrIn0));

  always_comb begin
    shadow_d    = shadow_q;
    snap_vld_d  = snap_vld_q;
    prev_addr_d = reg_addr;
    if (snap_trig) begin
      shadow_d   = in_data;
      snap_vld_d = 1'b1;
    end
    if (fc_soft) begin
      snap_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q    <= '0;
      snap_vld_q  <= 1'b0;
      prev_addr_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      snap_vld_q  <= snap_vld_d;
      prev_addr_q <= prev_addr_d;
    end
  end

  assign in_view  = shadow_q;
  assign snap_vld = snap_vld_q;
`else
  assign in_view  = in_data;
  assign snap_vld = 1'b0;
`endif

  // Register writes; fast commands are applied after the bus write so they
  // win on any register both touch.
  always_comb begin
    ctrl_d = ctrl_q;
    mask_d = mask_q;
    gp_d   = gp_q;
    if (wr_en) begin
      if (reg_addr == AddrCtrl) ctrl_d = reg_data_o;
      if (reg_addr == AddrMask) mask_d = reg_data_o[7:0];
      if (reg_addr == AddrGp0) gp_d[0*REG_W +: REG_W] = reg_data_o;
      if (reg_addr == AddrGp1) gp_d[1*REG_W +: REG_W] = reg_data_o;
      if (reg_addr == AddrGp2) gp_d[2*REG_W +: REG_W] = reg_data_o;
      if (reg_addr == AddrGp3) gp_d[3*REG_W +: REG_W] = reg_data_o;
    end
    if (fc_soft) begin
      ctrl_d = CTRL_RST;
      mask_d = '0;
      gp_d   = '0;
    end
  end

  // Interrupt path. arm_q masks the first cycle after reset so a source
  // already high at reset release does not look like a rising edge.
  always_comb begin
    hist_d = irq_src;
    edge_d = irq_src & ~hist_q & {8{arm_q}};
    arm_d  = 1'b1;

    flag_d = flag_q;
    if (wr_en && (reg_addr == AddrFlag)) flag_d = flag_d & ~reg_data_o[7:0];
    if (fc_clr) flag_d = '0;
    // A new edge beats both W1C and the clear command.
    flag_d = flag_d | edge_q;
    // Soft reset is a full clear of the bank, edges included.
    if (fc_soft) flag_d = '0;

    irq_d    = |(flag_q & mask_q);
    status_d = {irq_d, snap_vld, flag_q[5:0]};
  end

  // Read mux from current register contents; registered to give 1 clk latency.
  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      AddrId:   rdata_d = IdWord;
      AddrCtrl: rdata_d = ctrl_q;
      AddrFlag: rdata_d = {{(REG_W-8){1'b0}}, flag_q};
      AddrMask: rdata_d = {{(REG_W-8){1'b0}}, mask_q};
      AddrIn0:  rdata_d = in_view[0*REG_W +: REG_W];
      AddrIn1:  rdata_d = in_view[1*REG_W +: REG_W];
      AddrIn2:  rdata_d = in_view[2*REG_W +: REG_W];
      AddrIn3:  rdata_d = in_view[3*REG_W +: REG_W];
      AddrGp0:  rdata_d = gp_q[0*REG_W +: REG_W];
      AddrGp1:  rdata_d = gp_q[1*REG_W +: REG_W];
      AddrGp2:  rdata_d = gp_q[2*REG_W +: REG_W];
      AddrGp3:  rdata_d = gp_q[3*REG_W +: REG_W];
      default:  rdata_d = '0;
    endcase
  end

  // User command forwarding
  always_comb begin
    user_cmd_d     = user_cmd_q;
    user_cmd_vld_d = 1'b0;
    if (fc_user) begin
      user_cmd_d     = fastcmd;
      user_cmd_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q         <= CTRL_RST;
      mask_q         <= '0;
      flag_q         <= '0;
      gp_q           <= '0;
      hist_q         <= '0;
      edge_q         <= '0;
      arm_q          <= 1'b0;
      irq_q          <= 1'b0;
      status_q       <= '0;
      rdata_q        <= '0;
      user_cmd_q     <= '0;
      user_cmd_vld_q <= 1'b0;
    end else begin
      ctrl_q         <= ctrl_d;
      mask_q         <= mask_d;
      flag_q         <= flag_d;
      gp_q           <= gp_d;
      hist_q         <= hist_d;
      edge_q         <= edge_d;
      arm_q          <= arm_d;
      irq_q          <= irq_d;
      status_q       <= status_d;
      rdata_q        <= rdata_d;
      user_cmd_q     <= user_cmd_d;
      user_cmd_vld_q <= user_cmd_vld_d;
    end
  end

  assign reg_data_i   = rdata_q;
  assign status       = status_q;
  assign ctrl_o       = ctrl_q;
  assign gp_o         = gp_q;
  assign irq          = irq_q;
  assign user_cmd     = user_cmd_q;
  assign user_cmd_vld = user_cmd_vld_q;

endmodule

// File: tb/tb_spireg_regfile.sv
// Scoreboard bench for spireg_regfile: stimulus tasks update a register-level
// model and queue the values each output must show at a given cycle; a monitor
// on the falling edge pops and compares them, and separately checks every
// user_cmd_vld pulse against a queue of expected forwarded codes.

module tb_spireg_regfile;

  localparam int unsigned      AW   = 6;
  localparam int unsigned      RW   = 16;
  localparam logic [15:0]      IDV  = 16'h5A01;
  localparam logic [RW-1:0]    CRST = 16'h00C3;
`ifdef SPIREG_REGFILE_SNAPSHOT_EN
  localparam bit SnapEn = 1'b1;
`else
  localparam bit SnapEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   reg_addr;
  logic [RW-1:0]   reg_data_o;
  logic            reg_data_o_vld;
  logic [RW-1:0]   reg_data_i;
  logic [7:0]      status;
  logic [5:0]      fastcmd;
  logic            fastcmd_vld;
  logic [7:0]      irq_src;
  logic [4*RW-1:0] in_data;
  logic [RW-1:0]   ctrl_o;
  logic [4*RW-1:0] gp_o;
  logic            irq;
  logic [5:0]      user_cmd;
  logic            user_cmd_vld;

  spireg_regfile #(
    .ADDR_W   (AW),
    .REG_W    (RW),
    .ID_VAL   (IDV),
    .CTRL_RST (CRST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .reg_addr       (reg_addr),
    .reg_data_o     (reg_data_o),
    .reg_data_o_vld (reg_data_o_vld),
    .reg_data_i     (reg_data_i),
    .status         (status),
    .fastcmd        (fastcmd),
    .fastcmd_vld    (fastcmd_vld),
    .irq_src        (irq_src),
    .in_data        (in_data),
    .ctrl_o         (ctrl_o),
    .gp_o           (gp_o),
    .irq            (irq),
    .user_cmd       (user_cmd),
    .user_cmd_vld   (user_cmd_vld)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Output selectors for the scoreboard
  localparam int SelRd = 0, SelSt = 1, SelCtrl = 2, SelIrq = 3, SelGp0 = 4, SelUcmd = 8;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t       eq[$];
  logic [5:0] uq[$];

  // Reference model
  logic [RW-1:0] m_ctrl;
  logic [7:0]    m_mask;
  logic [7:0]    m_flag;
  logic [RW-1:0] m_gp[4];
  logic [RW-1:0] m_shadow[4];
  logic          m_snap;
  int            m_addr;

  function automatic logic [63:0] dut_val(input int sel);
    case (sel)
      SelRd:   return 64'(reg_data_i);
      SelSt:   return 64'(status);
      SelCtrl: return 64'(ctrl_o);
      SelIrq:  return 64'(irq);
      SelUcmd: return 64'(user_cmd);
      default: return 64'(gp_o[(sel-SelGp0)*RW +: RW]);
    endcase
  endfunction

  function automatic logic [RW-1:0] in_word(input int k);
    return in_data[k*RW +: RW];
  endfunction

  function automatic logic [RW-1:0] m_read(input int a);
    if (a == 0) return IDV;
    if (a == 1) return m_ctrl;
    if (a == 2) return RW'(m_flag);
    if (a == 3) return RW'(m_mask);
    if (a >= 4 && a <= 7) return SnapEn ? m_shadow[a-4] : in_word(a-4);
    if (a >= 8 && a <= 11) return m_gp[a-8];
    return '0;
  endfunction

  function automatic logic [7:0] m_status();
    return {|(m_flag & m_mask), m_snap, m_flag[5:0]};
  endfunction

  task automatic m_capture();
    for (int k = 0; k < 4; k++) m_shadow[k] = in_word(k);
    m_snap = 1'b1;
  endtask

  task automatic m_reset();
    m_ctrl = CRST;
    m_mask = '0;
    m_flag = '0;
    m_snap = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_gp[k]     = '0;
      m_shadow[k] = '0;
    end
  endtask

  task automatic sb_push(input string nm, input int sel, input int unsigned dly,
                         input logic [63:0] v);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sel  = sel;
    e.val  = v;
    e.name = nm;
    eq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int a);
    if (SnapEn && a == 4 && m_addr != 4) m_capture();
    m_addr   = a;
    reg_addr = AW'(a);
  endtask

  task automatic chk_reset(input int unsigned dly);
    sb_push("rst_rdata", SelRd, dly, 64'(0));
    sb_push("rst_status", SelSt, dly, 64'(0));
    sb_push("rst_ctrl", SelCtrl, dly, 64'(CRST));
    sb_push("rst_irq", SelIrq, dly, 64'(0));
    sb_push("rst_ucmd", SelUcmd, dly, 64'(0));
    for (int k = 0; k < 4; k++) sb_push("rst_gp", SelGp0 + k, dly, 64'(0));
  endtask

  task automatic wr(input int a, input logic [RW-1:0] d);
    step();
    set_addr(a);
    reg_data_o     = d;
    reg_data_o_vld = 1'b1;
    case (a)
      1:       m_ctrl = d;
      2:       m_flag = m_flag & ~d[7:0];
      3:       m_mask = d[7:0];
      8, 9, 10, 11: m_gp[a-8] = d;
      default: ;
    endcase
    sb_push("wr_ctrl", SelCtrl, 1, 64'(m_ctrl));
    for (int k = 0; k < 4; k++) sb_push("wr_gp", SelGp0 + k, 1, 64'(m_gp[k]));
    sb_push("wr_readback", SelRd, 2, 64'(m_read(a)));
    sb_push("wr_status", SelSt, 2, 64'(m_status()));
    sb_push("wr_irq", SelIrq, 2, 64'(|(m_flag & m_mask)));
    step();
    reg_data_o_vld = 1'b0;
    step();
  endtask

  task automatic rd(input int a);
    step();
    set_addr(a);
    sb_push("rd_data", SelRd, 2, 64'(m_read(a)));
    step();
    step();
  endtask

  task automatic fc(input logic [5:0] c);
    step();
    fastcmd     = c;
    fastcmd_vld = 1'b1;
    if (c == 6'h01) begin
      m_ctrl = CRST;
      m_mask = '0;
      m_flag = '0;
      m_snap = 1'b0;
      for (int k = 0; k < 4; k++) m_gp[k] = '0;
    end else if (c == 6'h02) begin
      m_flag = '0;
    end else if (c == 6'h03) begin
      if (SnapEn) m_capture();
    end else if (c >= 6'h04) begin
      uq.push_back(c);
    end
    sb_push("fc_ctrl", SelCtrl, 1, 64'(m_ctrl));
    for (int k = 0; k < 4; k++) sb_push("fc_gp", SelGp0 + k, 1, 64'(m_gp[k]));
    sb_push("fc_status", SelSt, 2, 64'(m_status()));
    step();
    fastcmd_vld = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] bits);
    step();
    irq_src = bits;
    step();
    irq_src = '0;
    step();
    step();
    m_flag = m_flag | bits;
  endtask

  // Monitor: compares queued expectations and every user_cmd pulse
  always @(negedge clk) begin
    logic [63:0] act;
    for (int i = int'(eq.size()) - 1; i >= 0; i--) begin
      if (eq[i].cyc <= cyc) begin
        checks++;
        act = dut_val(eq[i].sel);
        if (eq[i].cyc != cyc || act !== eq[i].val) begin
          failures++;
          $display("FAIL %s: got %0h want %0h (cycle %0d)", eq[i].name, act, eq[i].val,
                   eq[i].cyc);
        end
        eq.delete(i);
      end
    end
    if (user_cmd_vld === 1'b1) begin
      checks++;
      if (uq.size() == 0) begin
        failures++;
        $display("FAIL user_cmd_vld: got unexpected pulse code %0h want no pulse", user_cmd);
      end else begin
        act = 64'(uq.pop_front());
        if (64'(user_cmd) !== act) begin
          failures++;
          $display("FAIL user_cmd: got %0h want %0h", user_cmd, act);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    reg_addr = AW'(2);
    m_addr = 2;
    reg_data_o = '0;
    reg_data_o_vld = 1'b0;
    fastcmd = '0;
    fastcmd_vld = 1'b0;
    irq_src = '0;
    in_data = {$urandom, $urandom};
    m_reset();

    step();
    chk_reset(0);
    step();
    rst = 1'b0;

    // ID, GP write/read-back, write to read-only ID
    rd(0);
    wr(8, 16'hBEEF);
    wr(0, 16'h1234);
    rd(0);
    wr(1, 16'h00FF);

    // IRQ: mask bit0, pulse source 0, then W1C
    wr(3, 16'h0001);
    step();
    irq_src = 8'h01;
    sb_push("irq_early", SelIrq, 2, 64'(0));
    sb_push("irq_set", SelIrq, 3, 64'(1));
    sb_push("status_set", SelSt, 3, 64'(8'h81));
    step();
    irq_src = '0;
    step();
    step();
    m_flag = m_flag | 8'h01;
    wr(2, 16'h0001);

    // W1C coincident with a new edge: set wins
    step();
    irq_src = 8'h01;
    step();
    set_addr(2);
    reg_data_o = 16'h0001;
    reg_data_o_vld = 1'b1;
    step();
    reg_data_o_vld = 1'b0;
    irq_src = '0;
    m_flag = m_flag | 8'h01;
    sb_push("w1c_vs_set", SelRd, 1, 64'(m_read(2)));
    step();
    sb_push("w1c_vs_set_irq", SelIrq, 0, 64'(1));
    step();
    step();

    // Soft reset and user command forwarding
    wr(11, 16'h1111);
    fc(6'h01);
    rd(1);
    fc(6'h2A);
    fc(6'h00);

    // Clear-all command
    pulse(8'h08);
    rd(2);
    fc(6'h02);
    rd(2);

    // Snapshot vs live IN reads
    step();
    in_data[1*RW +: RW] = 16'hAAAA;
    fc(6'h03);
    step();
    in_data[1*RW +: RW] = 16'h5555;
    rd(5);

    // Reset mid-operation with a flag set, GP programmed, source held across release
    wr(9, 16'h7777);
    wr(3, 16'h00FF);
    pulse(8'h01);
    rd(3);
    step();
    rst = 1'b1;
    irq_src = 8'h02;
    m_reset();
    chk_reset(1);
    step();
    rst = 1'b0;
    repeat (4) step();
    rd(2);
    sb_push("no_flag_after_rst", SelSt, 0, 64'(0));

    // Randomised traffic with stable in_data
    step();
    in_data = {$urandom, $urandom};
    if (SnapEn) fc(6'h03);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0, 1: wr(int'($urandom_range(0, 15)), RW'($urandom));
        2:    rd(int'($urandom_range(0, 15)));
        default: fc(6'($urandom_range(0, 63)));
      endcase
    end

    repeat (4) step();
    checks++;
    if (eq.size() != 0 || uq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending want 0/0", eq.size(), uq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
